mmio_timer: RTL and testbench
=============================

# mmio_timer

Memory-mapped down-counting timer that acts as a responder on the CPU data-memory bus (`memwrite`/`memaddr`/`memwritedata` in, `memreaddata` out). It sits beside data memory in the MIPS system, decodes its own 16-byte window, and returns read data in the same cycle. The CPU needs this because its MEM stage samples read data at the next clock edge. It provides a prescaled 32-bit counter with one-shot and auto-reload modes, a sticky expiry flag and a level interrupt.

## Interface
- `BASE_ADDR`, default 32'hFFFF_0000: base of the 16-byte register window; bits [3:0] must be 0.
- `PRESCALE_W`, default 8: width of the prescale field and of the prescale counter.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `memwrite` in 1: write strobe from the CPU MEM stage.
- `memaddr` in 32: byte address; bits [1:0] are ignored.
- `memwritedata` in 32: write data.
- `memreaddata` out 32: combinational read data; 0 when `sel`=0.
- `sel` out 1: combinational, high when `memaddr[31:4]`==`BASE_ADDR[31:4]`. The system read mux uses it.
- `irq` out 1: equals `STATUS.EXPIRED & CTRL.IE`, driven from registers.

## Operation
- Register map, selected by `memaddr[3:2]`:
  - 0x0 CTRL: [0] EN, [1] AUTO, [2] IE, [8+PRESCALE_W-1:8] PRESCALE.
  - 0x4 LOAD: reload value, 32 bits.
  - 0x8 COUNT: current count.
  - 0xC STATUS: [0] EXPIRED (write 1 to clear), [1] RUNNING.
- Unused bits read 0; writes to unused bits are ignored.
- A write happens on the clock edge with `memwrite & sel`. Reads have no side effects.
- States: IDLE, RUN, DONE. The state is encoded in 2 bits.
  - CTRL.EN reads 1 only in RUN. STATUS.RUNNING equals CTRL.EN.
- Transitions:
  - IDLE/DONE, CTRL written with EN=1 → RUN. COUNT←LOAD, prescaler←0.
  - RUN, CTRL written with EN=0 → IDLE. COUNT holds.
  - RUN, CTRL written with EN=1 → stays RUN. AUTO, IE and PRESCALE are updated. No reload.
  - RUN, tick with COUNT==0: EXPIRED←1. If AUTO=1, COUNT←LOAD and stay in RUN. If AUTO=0, go to DONE with COUNT=0.
  - RUN, tick with COUNT≠0: COUNT←COUNT−1.
- Tick generation: in RUN the prescaler increments every cycle. A tick is generated when prescaler==PRESCALE, and the prescaler then returns to 0. Outside RUN the prescaler is held at 0.
- Period with LOAD=N and PRESCALE=P: EXPIRED sets (N+1)·(P+1) cycles after the enabling edge. In auto-reload mode it repeats with the same period.
- Writing COUNT stores `memwritedata` in any state, and in RUN also resets the prescaler to 0. A COUNT write wins over a same-cycle decrement or reload.
- Writing LOAD affects only the next reload.
- Same-cycle EXPIRED set and a W1C clear of EXPIRED: the set wins.

## Timing
- Reset values: CTRL=0, LOAD=0, COUNT=0, EXPIRED=0, prescaler=0, state=IDLE, `irq`=0.
- `memreaddata` and `sel` reflect register contents as of the last clock edge, with zero latency.
- A written value is readable on the cycle after the write edge.
- EXPIRED and `irq` rise on the tick edge itself and are visible in the following cycle.
- `reset` asserted mid-count returns every register to its reset value at the next edge, in any state.
- Wrap-around: COUNT never underflows. The value 0 always produces an expiry on the next tick, never 32'hFFFF_FFFF.
- LOAD=0 with AUTO=1 expires on every tick.

## Structure
- Shared package `mmio_timer_pkg` holds:
  - register offsets (`TMR_CTRL`=2'd0 … `TMR_STATUS`=2'd3),
  - CTRL and STATUS bit positions,
  - state encodings (`TMR_IDLE`, `TMR_RUN`, `TMR_DONE`).
- One sub-module, `timer_prescaler`, with inputs `clk`, `reset`, `run`, `clr` and `limit[PRESCALE_W-1:0]`, and output `tick`.
- Register file, address decode and FSM stay in `mmio_timer`.

## Test plan
- Reset: read all four offsets → 0. `irq`=0. `sel`=1 only for addresses 0xFFFF_0000–0xFFFF_000F, with `memreaddata`=0 outside the window.
- One-shot: write LOAD=3, then CTRL=0x0000_0205 (EN, IE, PRESCALE=2). Required:
  - EXPIRED and `irq` set exactly 12 cycles after the CTRL write edge.
  - CTRL.EN then reads 0 and COUNT reads 0.
  - Writing STATUS=1 clears `irq`.
- Auto-reload: LOAD=1, CTRL=0x3 (EN, AUTO, PRESCALE=0) → expiry every 2 cycles, COUNT sequence 1,0,1,0…, no underflow.
- Simultaneous events: issue a W1C STATUS write in the same cycle as an expiry tick → EXPIRED reads 1. Write COUNT=5 in the same cycle as a tick → COUNT reads 5.
- Disable and restart: write CTRL EN=0 mid-count at COUNT=7 → COUNT holds 7 in IDLE. Re-enable with LOAD=9 → COUNT reads 9.
- Reset mid-RUN with EXPIRED=1 and `irq`=1 → all registers read 0 and `irq`=0 on the cycle after the reset edge.

Source files
------------

// File: rtl/mmio_timer_pkg.sv
// mmio_timer_pkg: shared definitions for the memory-mapped timer.
//   - register offsets within the 16-byte window (memaddr[3:2])
//   - CTRL / STATUS bit positions
//   - FSM state encodings
package mmio_timer_pkg;

  // Register offsets, word index memaddr[3:2]
  localparam logic [1:0] TMR_CTRL   = 2'd0;
  localparam logic [1:0] TMR_LOAD   = 2'd1;
  localparam logic [1:0] TMR_COUNT  = 2'd2;
  localparam logic [1:0] TMR_STATUS = 2'd3;

  // CTRL bit positions
  localparam int unsigned CTRL_EN_BIT       = 0;
  localparam int unsigned CTRL_AUTO_BIT     = 1;
  localparam int unsigned CTRL_IE_BIT       = 2;
  localparam int unsigned CTRL_PRESCALE_LSB = 8;

  // STATUS bit positions
  localparam int unsigned STATUS_EXPIRED_BIT = 0;
  localparam int unsigned STATUS_RUNNING_BIT = 1;

  typedef enum logic [1:0] {
    TMR_IDLE = 2'd0,
    TMR_RUN  = 2'd1,
    TMR_DONE = 2'd2
  } tmr_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides the clock into single-cycle ticks while running.
//   clk   in  : clock
//   reset in  : synchronous active-high reset
//   run   in  : count enable; counter is held at 0 when low
//   clr   in  : restart the prescale period (counter back to 0)
//   limit in  : a tick is issued when the counter equals limit (period limit+1)
//   tick  out : combinational, one cycle per period
module timer_prescaler #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] limit,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] r_cnt;
  logic [PRESCALE_W-1:0] w_cnt_next;

  assign tick = run & (r_cnt == limit);

  always_comb begin
    w_cnt_next = r_cnt + 1'b1;
    if (!run || clr || tick) begin
      w_cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped prescaled 32-bit down-counter on the CPU data bus.
//   clk          in  : clock
//   reset        in  : synchronous active-high reset
//   memwrite     in  : write strobe
//   memaddr      in  : byte address (bits [1:0] ignored)
//   memwritedata in  : write data
//   memreaddata  out : combinational read data, 0 when not selected
//   sel          out : address falls in this block's 16-byte window
//   irq          out : STATUS.EXPIRED & CTRL.IE
// Registers: 0x0 CTRL, 0x4 LOAD, 0x8 COUNT, 0xC STATUS (EXPIRED is W1C).
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic [31:0] memreaddata,
  output logic        sel,
  output logic        irq
);

  tmr_state_e            r_state, w_state_d;
  logic                  r_auto, w_auto_d;
  logic                  r_ie, w_ie_d;
  logic [PRESCALE_W-1:0] r_prescale, w_prescale_d;
  logic [31:0]           r_load, w_load_d;
  logic [31:0]           r_count, w_count_d;
  logic                  r_expired, w_expired_d;

  logic       w_run;
  logic       w_tick;
  logic       w_wr;
  logic [1:0] w_off;
  logic       w_wr_ctrl, w_wr_load, w_wr_count, w_wr_status;
  logic       w_new_en;
  logic       w_presc_clr;
  logic       w_unused;

  assign w_unused = ^memaddr[1:0];

  assign sel         = (memaddr[31:4] == BASE_ADDR[31:4]);
  assign w_wr        = memwrite & sel;
  assign w_off       = memaddr[3:2];
  assign w_wr_ctrl   = w_wr & (w_off == TMR_CTRL);
  assign w_wr_load   = w_wr & (w_off == TMR_LOAD);
  assign w_wr_count  = w_wr & (w_off == TMR_COUNT);
  assign w_wr_status = w_wr & (w_off == TMR_STATUS);
  assign w_new_en    = memwritedata[CTRL_EN_BIT];
  assign w_run       = (r_state == TMR_RUN);

  // Restart the prescale period on a COUNT write or when starting a run.
  assign w_presc_clr = w_wr_count | (w_wr_ctrl & w_new_en & ~w_run);

  timer_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .run  (w_run),
    .clr  (w_presc_clr),
    .limit(r_prescale),
    .tick (w_tick)
  );

  assign irq = r_expired & r_ie;

  always_comb begin
    w_state_d    = r_state;
    w_auto_d     = r_auto;
    w_ie_d       = r_ie;
    w_prescale_d = r_prescale;
    w_load_d     = r_load;
    w_count_d    = r_count;
    w_expired_d  = r_expired;

    if (w_wr_ctrl) begin
      w_auto_d     = memwritedata[CTRL_AUTO_BIT];
      w_ie_d       = memwritedata[CTRL_IE_BIT];
      w_prescale_d = memwritedata[CTRL_PRESCALE_LSB +: PRESCALE_W];
    end
    if (w_wr_load) begin
      w_load_d = memwritedata;
    end
    // W1C clear first so a same-cycle expiry below overrides it.
    if (w_wr_status && memwritedata[STATUS_EXPIRED_BIT]) begin
      w_expired_d = 1'b0;
    end

    case (r_state)
      TMR_RUN: begin
        if (w_wr_ctrl && !w_new_en) begin
          // Disabling freezes the count where it stands.
          w_state_d = TMR_IDLE;
        end else if (w_tick) begin
          if (r_count == 32'd0) begin
            w_expired_d = 1'b1;
            if (r_auto) begin
              w_count_d = r_load;
            end else begin
              w_state_d = TMR_DONE;
            end
          end else begin
            w_count_d = r_count - 32'd1;
          end
        end
      end
      TMR_IDLE, TMR_DONE: begin
        if (w_wr_ctrl && w_new_en) begin
          w_state_d = TMR_RUN;
          w_count_d = r_load;
        end
      end
      default: begin
        w_state_d = TMR_IDLE;
      end
    endcase

    // Software COUNT write overrides any decrement or reload this cycle.
    if (w_wr_count) begin
      w_count_d = memwritedata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= TMR_IDLE;
      r_auto     <= 1'b0;
      r_ie       <= 1'b0;
      r_prescale <= '0;
      r_load     <= '0;
      r_count    <= '0;
      r_expired  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_auto     <= w_auto_d;
      r_ie       <= w_ie_d;
      r_prescale <= w_prescale_d;
      r_load     <= w_load_d;
      r_count    <= w_count_d;
      r_expired  <= w_expired_d;
    end
  end

  always_comb begin
    memreaddata = '0;
    if (sel) begin
      case (w_off)
        TMR_CTRL: begin
          memreaddata[CTRL_EN_BIT]                        = w_run;
          memreaddata[CTRL_AUTO_BIT]                      = r_auto;
          memreaddata[CTRL_IE_BIT]                        = r_ie;
          memreaddata[CTRL_PRESCALE_LSB +: PRESCALE_W]    = r_prescale;
        end
        TMR_LOAD:  memreaddata = r_load;
        TMR_COUNT: memreaddata = r_count;
        TMR_STATUS: begin
          memreaddata[STATUS_EXPIRED_BIT] = r_expired;
          memreaddata[STATUS_RUNNING_BIT] = w_run;
        end
        default: memreaddata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed self-checking bench for mmio_timer.
module tb_mmio_timer;

  localparam logic [31:0] A_CTRL   = 32'hFFFF_0000;
  localparam logic [31:0] A_LOAD   = 32'hFFFF_0004;
  localparam logic [31:0] A_COUNT  = 32'hFFFF_0008;
  localparam logic [31:0] A_STATUS = 32'hFFFF_000C;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;
  logic        sel;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  mmio_timer dut (
    .clk         (clk),
    .reset       (reset),
    .memwrite    (memwrite),
    .memaddr     (memaddr),
    .memwritedata(memwritedata),
    .memreaddata (memreaddata),
    .sel         (sel),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; reads settle for 1ns before sampling.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    memwrite     = 1'b1;
    memaddr      = addr;
    memwritedata = data;
    @(posedge clk);
    #1;
    memwrite     = 1'b0;
    memwritedata = '0;
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    memaddr = addr;
    #1;
    chk(tag, memreaddata, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    clk          = 1'b0;
    reset        = 1'b1;
    memwrite     = 1'b0;
    memaddr      = '0;
    memwritedata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state and decode window
    rd("rst_ctrl", A_CTRL, 32'h0);
    rd("rst_load", A_LOAD, 32'h0);
    rd("rst_count", A_COUNT, 32'h0);
    rd("rst_status", A_STATUS, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("sel_top", {31'b0, sel}, 32'h1);
    memaddr = 32'hFFFF_0010;
    #1;
    chk("sel_above", {31'b0, sel}, 32'h0);
    chk("rdata_outside", memreaddata, 32'h0);
    memaddr = 32'hFFFE_FFFC;
    #1;
    chk("sel_below", {31'b0, sel}, 32'h0);
    wr(32'hFFFF_0014, 32'h55);
    rd("wr_outside_ignored", A_LOAD, 32'h0);

    // One-shot: LOAD=3, PRESCALE=2 -> expiry 12 cycles after enabling edge
    wr(A_LOAD, 32'd3);
    wr(A_CTRL, 32'h0000_0205);
    rd("os_ctrl", A_CTRL, 32'h0000_0205);
    rd("os_count_start", A_COUNT, 32'd3);
    cyc(11);
    rd("os_status_e11", A_STATUS, 32'h2);
    rd("os_count_e11", A_COUNT, 32'd0);
    chk("os_irq_e11", {31'b0, irq}, 32'h0);
    cyc(1);
    chk("os_irq_e12", {31'b0, irq}, 32'h1);
    rd("os_status_e12", A_STATUS, 32'h1);
    rd("os_ctrl_done", A_CTRL, 32'h0000_0204);
    rd("os_count_done", A_COUNT, 32'd0);
    wr(A_STATUS, 32'h1);
    chk("os_irq_cleared", {31'b0, irq}, 32'h0);
    rd("os_status_cleared", A_STATUS, 32'h0);

    // Auto-reload: LOAD=1, PRESCALE=0 -> 1,0,1,0 with expiry every 2 cycles
    wr(A_LOAD, 32'd1);
    wr(A_CTRL, 32'h3);
    rd("ar_count_e0", A_COUNT, 32'd1);
    cyc(1);
    rd("ar_count_e1", A_COUNT, 32'd0);
    rd("ar_status_e1", A_STATUS, 32'h2);
    cyc(1);
    rd("ar_count_e2", A_COUNT, 32'd1);
    rd("ar_status_e2", A_STATUS, 32'h3);
    cyc(1);
    rd("ar_count_e3", A_COUNT, 32'd0);
    cyc(1);
    rd("ar_count_e4", A_COUNT, 32'd1);
    cyc(1);
    rd("ar_count_e5", A_COUNT, 32'd0);
    // W1C on the expiry edge: set wins
    wr(A_STATUS, 32'h1);
    rd("sim_w1c_vs_set", A_STATUS, 32'h3);
    rd("sim_reload", A_COUNT, 32'd1);
    wr(A_STATUS, 32'h1);
    rd("w1c_plain", A_STATUS, 32'h2);
    // COUNT write on a tick edge wins over the tick
    wr(A_COUNT, 32'd5);
    rd("sim_count_wr", A_COUNT, 32'd5);
    cyc(1);
    rd("count_after_wr", A_COUNT, 32'd4);

    // Disable mid-count at 7, then restart with LOAD=9
    wr(A_CTRL, 32'h0);
    wr(A_LOAD, 32'd8);
    wr(A_CTRL, 32'h0000_0301);
    rd("dr_count_start", A_COUNT, 32'd8);
    cyc(4);
    rd("dr_count_7", A_COUNT, 32'd7);
    wr(A_CTRL, 32'h0000_0300);
    rd("dr_ctrl_idle", A_CTRL, 32'h0000_0300);
    rd("dr_count_hold", A_COUNT, 32'd7);
    cyc(3);
    rd("dr_count_hold3", A_COUNT, 32'd7);
    wr(A_LOAD, 32'd9);
    wr(A_CTRL, 32'h1);
    rd("dr_restart_count", A_COUNT, 32'd9);
    rd("dr_restart_ctrl", A_CTRL, 32'h1);

    // Enable IE while running with EXPIRED still set, then reset
    wr(A_CTRL, 32'h5);
    chk("pre_rst_irq", {31'b0, irq}, 32'h1);
    rd("pre_rst_status", A_STATUS, 32'h3);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid_rst_irq", {31'b0, irq}, 32'h0);
    rd("mid_rst_ctrl", A_CTRL, 32'h0);
    rd("mid_rst_load", A_LOAD, 32'h0);
    rd("mid_rst_count", A_COUNT, 32'h0);
    rd("mid_rst_status", A_STATUS, 32'h0);

    // LOAD=0 with AUTO: expires on every tick, never wraps
    wr(A_CTRL, 32'h3);
    cyc(1);
    rd("z_status", A_STATUS, 32'h3);
    rd("z_count", A_COUNT, 32'h0);
    wr(A_STATUS, 32'h1);
    rd("z_status_again", A_STATUS, 32'h3);
    rd("z_count_again", A_COUNT, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
